button_event: RTL and testbench

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_event_pkg.sv | 17 +
 rtl/button_event_if.sv | 14 +
 rtl/button_event_slot.sv | 53 +++++
 rtl/button_event.sv | 110 +++++++++++
 tb/tb_button_event.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/button_event_pkg.sv
// Shared types for the button event generator: event codes and FSM states.
package button_event_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_LONG    = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHORT = 2'b01,
    ST_HELD  = 2'b10
  } state_e;

endpackage

// File: rtl/button_event_if.sv
// Event handshake bundle: producer (master) presents events, consumer (slave) acks.
interface button_event_if;
  import button_event_pkg::*;

  logic      evt_valid;
  evt_code_e evt_code;
  logic      evt_ack;
  logic      evt_overrun;
  logic      overrun_clr;

  modport master (output evt_valid, evt_code, evt_overrun, input evt_ack, overrun_clr);
  modport slave  (input evt_valid, evt_code, evt_overrun, output evt_ack, overrun_clr);

endinterface

// File: rtl/button_event_slot.sv
// Single-entry event holding register with ack and sticky overrun flag.
module button_event_slot
  import button_event_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      new_vld_i,
  input  evt_code_e new_code_i,
  input  logic      ack_i,
  input  logic      clr_i,
  output logic      vld_o,
  output evt_code_e code_o,
  output logic      ovr_o
);

  logic      vld_q, vld_d;
  evt_code_e code_q, code_d;
  logic      ovr_q, ovr_d;
  logic      accept, drop;

  // An ack in the same cycle frees the slot for the incoming event.
  assign accept = new_vld_i && (!vld_q || ack_i);
  assign drop   = new_vld_i && vld_q && !ack_i;

  always_comb begin
    vld_d  = vld_q;
    code_d = code_q;
    if (accept) begin
      vld_d  = 1'b1;
      code_d = new_code_i;
    end else if (ack_i) begin
      vld_d  = 1'b0;
    end
    ovr_d = drop | (ovr_q & ~clr_i);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      code_q <= EVT_PRESS;
      ovr_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      code_q <= code_d;
      ovr_q  <= ovr_d;
    end
  end

  assign vld_o  = vld_q;
  assign code_o = code_q;
  assign ovr_o  = ovr_q;

endmodule

// File: rtl/button_event.sv
// Button event generator: PRESS/RELEASE/LONG (+REPEAT when BUTTON_EVENT_REPEAT_EN
// is defined) from a debounced level, delivered through a one-entry slot.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 16'd50000,
  parameter int unsigned REPEAT_CYCLES = 16'd10000,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 botao_filtrado,
  output logic                 pressed,
  button_event_if.master       evt
);

  // Counter is 0 on the generating edge, so the Nth edge after it sees N-1.
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);
`endif

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 btn_q;
  logic                 gen_vld;
  evt_code_e            gen_code;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    gen_vld  = 1'b0;
    gen_code = EVT_PRESS;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (botao_filtrado && !btn_q) begin
          gen_vld  = 1'b1;
          gen_code = EVT_PRESS;
          cnt_d    = '0;
          state_d  = ST_SHORT;
        end
      end
      ST_SHORT: begin
        if (!botao_filtrado) begin
          gen_vld  = 1'b1;
          gen_code = EVT_RELEASE;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else if (cnt_q >= HOLD_LAST) begin
          gen_vld  = 1'b1;
          gen_code = EVT_LONG;
          cnt_d    = '0;
          state_d  = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!botao_filtrado) begin
          gen_vld  = 1'b1;
          gen_code = EVT_RELEASE;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
          if (cnt_q >= REP_LAST) begin
            gen_vld  = 1'b1;
            gen_code = EVT_REPEAT;
            cnt_d    = '0;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= botao_filtrado;
    end
  end

  assign pressed = btn_q;

  button_event_slot u_slot (
    .clock      (clock),
    .reset_n    (reset_n),
    .new_vld_i  (gen_vld),
    .new_code_i (gen_code),
    .ack_i      (evt.evt_ack),
    .clr_i      (evt.overrun_clr),
    .vld_o      (evt.evt_valid),
    .code_o     (evt.evt_code),
    .ovr_o      (evt.evt_overrun)
  );

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with HOLD_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event;
  import button_event_pkg::*;

  logic clock;
  logic reset_n;
  logic botao_filtrado;
  logic pressed;
  int   checks;
  int   fails;

  button_event_if bif ();

  button_event #(
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .CNT_WIDTH     (8)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .botao_filtrado (botao_filtrado),
    .pressed        (pressed),
    .evt            (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_evt(input string tag, input logic v, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(bif.evt_valid), 32'(v));
    if (v) chk({tag, ".code"}, 32'(bif.evt_code), 32'(c));
  endtask

  initial begin
    logic       ev;
    logic [1:0] ec;
    logic       rep_en;
    checks = 0;
    fails  = 0;
`ifdef BUTTON_EVENT_REPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
    reset_n         = 1'b0;
    botao_filtrado  = 1'b0;
    bif.evt_ack     = 1'b1;
    bif.overrun_clr = 1'b0;
    tick();
    tick();
    chk("rst.valid",   32'(bif.evt_valid),   32'd0);
    chk("rst.code",    32'(bif.evt_code),    32'd0);
    chk("rst.overrun", 32'(bif.evt_overrun), 32'd0);
    chk("rst.pressed", 32'(pressed),         32'd0);
    reset_n = 1'b1;
    tick();
    tick();

    // Short press: 1 for three sampled edges, then 0.
    botao_filtrado = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      tick();
      ev = (i == 0) || (i == 3);
      ec = (i == 3) ? 2'b01 : 2'b00;
      expect_evt($sformatf("short.p%0d", i), ev, ec);
      if (i == 0) chk("short.pressed1", 32'(pressed), 32'd1);
      if (i == 3) chk("short.pressed0", 32'(pressed), 32'd0);
      if (i == 2) botao_filtrado = 1'b0;
    end

    // Long hold: 18 sampled 1s.
    botao_filtrado = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      tick();
      ev = 1'b0;
      ec = 2'b00;
      case (i)
        0:       begin ev = 1'b1; ec = 2'b00; end
        8:       begin ev = 1'b1; ec = 2'b10; end
        12, 16:  begin ev = rep_en; ec = 2'b11; end
        18:      begin ev = 1'b1; ec = 2'b01; end
        default: ;
      endcase
      expect_evt($sformatf("hold.p%0d", i), ev, ec);
      if (i == 17) botao_filtrado = 1'b0;
    end
    chk("hold.overrun", 32'(bif.evt_overrun), 32'd0);

    // No ack: RELEASE dropped behind pending PRESS.
    bif.evt_ack    = 1'b0;
    botao_filtrado = 1'b1;
    tick();
    expect_evt("noack.press", 1'b1, 2'b00);
    chk("noack.ovr0", 32'(bif.evt_overrun), 32'd0);
    botao_filtrado = 1'b0;
    tick();
    expect_evt("noack.kept", 1'b1, 2'b00);
    chk("noack.ovr1", 32'(bif.evt_overrun), 32'd1);
    tick();
    chk("noack.sticky", 32'(bif.evt_overrun), 32'd1);
    bif.overrun_clr = 1'b1;
    tick();
    chk("noack.clr", 32'(bif.evt_overrun), 32'd0);
    bif.overrun_clr = 1'b0;
    bif.evt_ack     = 1'b1;
    tick();
    expect_evt("noack.drain", 1'b0, 2'b00);

    // Drop and clear in the same cycle: set wins.
    bif.evt_ack    = 1'b0;
    botao_filtrado = 1'b1;
    tick();
    botao_filtrado  = 1'b0;
    bif.overrun_clr = 1'b1;
    tick();
    chk("setwins.ovr", 32'(bif.evt_overrun), 32'd1);
    bif.overrun_clr = 1'b1;
    bif.evt_ack     = 1'b1;
    tick();
    chk("setwins.cleared", 32'(bif.evt_overrun), 32'd0);
    bif.overrun_clr = 1'b0;
    tick();

    // Ack coincides with RELEASE generation: replace, no overrun.
    bif.evt_ack    = 1'b0;
    botao_filtrado = 1'b1;
    tick();
    expect_evt("ackrel.press", 1'b1, 2'b00);
    botao_filtrado = 1'b0;
    bif.evt_ack    = 1'b1;
    tick();
    expect_evt("ackrel.release", 1'b1, 2'b01);
    chk("ackrel.ovr", 32'(bif.evt_overrun), 32'd0);
    tick();
    expect_evt("ackrel.drain", 1'b0, 2'b00);
    tick();

    // Reset in HELD with LONG pending; button still down afterwards.
    botao_filtrado = 1'b1;
    for (int i = 0; i <= 8; i++) tick();
    expect_evt("rsth.long", 1'b1, 2'b10);
    bif.evt_ack = 1'b0;
    tick();
    expect_evt("rsth.pending", 1'b1, 2'b10);
    reset_n = 1'b0;
    tick();
    chk("rsth.valid",   32'(bif.evt_valid),   32'd0);
    chk("rsth.code",    32'(bif.evt_code),    32'd0);
    chk("rsth.pressed", 32'(pressed),         32'd0);
    chk("rsth.ovr",     32'(bif.evt_overrun), 32'd0);
    reset_n     = 1'b1;
    bif.evt_ack = 1'b1;
    tick();
    expect_evt("rsth.repress", 1'b1, 2'b00);
    chk("rsth.pressed1", 32'(pressed), 32'd1);
    botao_filtrado = 1'b0;
    tick();
    expect_evt("rsth.release", 1'b1, 2'b01);
    tick();
    expect_evt("rsth.idle", 1'b0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
